// File: rtl/llc_req_sequencer.sv
// Per-request LLC transaction sequencer: orders L1 messages, bus operations and the final MESI update.
// Optional statistics counters are built when LLC_REQ_SEQ_STATS_EN is defined.
module llc_req_sequencer #(
  parameter  int ASSOC = 8,
  localparam int WAY_W = $clog2(ASSOC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_addr,
  input  logic             lk_hit,
  input  logic [WAY_W-1:0] lk_hit_way,
  input  logic [1:0]       lk_state,
  input  logic [WAY_W-1:0] lk_victim_way,
  input  logic [1:0]       lk_victim_state,
  input  logic [10:0]      lk_victim_tag,
  output logic             bus_valid,
  output logic [2:0]       bus_op,
  output logic [31:0]      bus_addr,
  input  logic             bus_ready,
  input  logic [1:0]       bus_snoop,
  output logic             l1_valid,
  output logic [2:0]       l1_msg,
  output logic [31:0]      l1_addr,
  input  logic             l1_ready,
  output logic             upd_valid,
  output logic [WAY_W-1:0] upd_way,
  output logic [14:0]      upd_index,
  output logic [10:0]      upd_tag,
  output logic [1:0]       upd_state,
  output logic             done,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses,
  output logic [31:0]      stat_wbacks
);

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  localparam logic [1:0] SNOOP_NOHIT = 2'd0;

  localparam logic [2:0] BUS_READ  = 3'd1;
  localparam logic [2:0] BUS_WRITE = 3'd2;
  localparam logic [2:0] BUS_INVAL = 3'd3;
  localparam logic [2:0] BUS_RWIM  = 3'd4;

  localparam logic [2:0] L1_GETLINE  = 3'd1;
  localparam logic [2:0] L1_SENDLINE = 3'd2;
  localparam logic [2:0] L1_EVICTLN  = 3'd4;

  typedef enum logic [2:0] {
    IDLE, L1_GET, L1_EVICT, BUS_WB, BUS_INV, BUS_FILL, L1_SEND, UPDATE
  } state_t;

  state_t state, state_nxt;

  logic             op_p0;
  logic [31:6]      line_p0;
  logic             hit_p0;
  logic [WAY_W-1:0] hit_way_p0;
  logic [1:0]       state_p0;
  logic [WAY_W-1:0] vic_way_p0;
  logic [1:0]       vic_state_p0;
  logic [10:0]      vic_tag_p0;
  logic [1:0]       snoop_p0;

  logic        accept;
  logic [31:0] req_line;
  logic [31:0] vic_line;
  logic [5:0]  addr_offset_unused;

  function automatic state_t entry_state(input logic op, input logic hit,
                                         input logic [1:0] st, input logic [1:0] vst);
    if (hit) return (op && st == MESI_S) ? BUS_INV : L1_SEND;
    if (vst == MESI_M) return L1_GET;
    if (vst == MESI_I) return BUS_FILL;
    return L1_EVICT;
  endfunction

  // Reserved snoop code 3 falls into the shared (non-NOHIT) branch.
  function automatic logic [1:0] final_state(input logic op, input logic hit,
                                             input logic [1:0] st, input logic [1:0] snoop);
    if (op) return MESI_M;
    if (hit) return st;
    return (snoop == SNOOP_NOHIT) ? MESI_E : MESI_S;
  endfunction

  assign accept             = req_valid && req_ready;
  assign addr_offset_unused = req_addr[5:0];
  assign req_line           = {line_p0, 6'b0};
  assign vic_line           = {vic_tag_p0, line_p0[20:6], 6'b0};

  // Stage p0: request and lookup capture on accept; snoop capture on fill handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0        <= req_op;
      line_p0      <= req_addr[31:6];
      hit_p0       <= lk_hit;
      hit_way_p0   <= lk_hit_way;
      state_p0     <= lk_state;
      vic_way_p0   <= lk_victim_way;
      vic_state_p0 <= lk_victim_state;
      vic_tag_p0   <= lk_victim_tag;
    end
    if (state == BUS_FILL && bus_ready) snoop_p0 <= bus_snoop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    bus_valid = 1'b0;
    bus_op    = 3'd0;
    bus_addr  = 32'd0;
    l1_valid  = 1'b0;
    l1_msg    = 3'd0;
    l1_addr   = 32'd0;
    upd_valid = 1'b0;
    upd_way   = '0;
    upd_index = 15'd0;
    upd_tag   = 11'd0;
    upd_state = 2'd0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = entry_state(req_op, lk_hit, lk_state, lk_victim_state);
      end
      L1_GET: begin
        l1_valid = 1'b1;
        l1_msg   = L1_GETLINE;
        l1_addr  = vic_line;
        if (l1_ready) state_nxt = L1_EVICT;
      end
      L1_EVICT: begin
        l1_valid = 1'b1;
        l1_msg   = L1_EVICTLN;
        l1_addr  = vic_line;
        if (l1_ready) state_nxt = (vic_state_p0 == MESI_M) ? BUS_WB : BUS_FILL;
      end
      BUS_WB: begin
        bus_valid = 1'b1;
        bus_op    = BUS_WRITE;
        bus_addr  = vic_line;
        if (bus_ready) state_nxt = BUS_FILL;
      end
      BUS_INV: begin
        bus_valid = 1'b1;
        bus_op    = BUS_INVAL;
        bus_addr  = req_line;
        if (bus_ready) state_nxt = L1_SEND;
      end
      BUS_FILL: begin
        bus_valid = 1'b1;
        bus_op    = op_p0 ? BUS_RWIM : BUS_READ;
        bus_addr  = req_line;
        if (bus_ready) state_nxt = L1_SEND;
      end
      L1_SEND: begin
        l1_valid = 1'b1;
        l1_msg   = L1_SENDLINE;
        l1_addr  = req_line;
        if (l1_ready) state_nxt = UPDATE;
      end
      UPDATE: begin
        upd_valid = 1'b1;
        done      = 1'b1;
        upd_way   = hit_p0 ? hit_way_p0 : vic_way_p0;
        upd_index = line_p0[20:6];
        upd_tag   = line_p0[31:21];
        upd_state = final_state(op_p0, hit_p0, state_p0, snoop_p0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LLC_REQ_SEQ_STATS_EN
  logic [31:0] hits_q, misses_q, wbacks_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= 32'd0;
      misses_q <= 32'd0;
      wbacks_q <= 32'd0;
    end else if (accept) begin
      if (lk_hit) begin
        hits_q <= sat_inc(hits_q);
      end else begin
        misses_q <= sat_inc(misses_q);
        if (lk_victim_state == MESI_M) wbacks_q <= sat_inc(wbacks_q);
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_wbacks = wbacks_q;
`else
  assign stat_hits   = 32'd0;
  assign stat_misses = 32'd0;
  assign stat_wbacks = 32'd0;
`endif

endmodule

// File: tb/tb_llc_req_sequencer.sv
// Randomized and directed bench for llc_req_sequencer against a transaction-list reference model.
module tb_llc_req_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [31:0] req_addr = '0;
  logic        lk_hit = 1'b0;
  logic [2:0]  lk_hit_way = '0, lk_victim_way = '0;
  logic [1:0]  lk_state = '0, lk_victim_state = '0;
  logic [10:0] lk_victim_tag = '0;
  logic        bus_valid, bus_ready = 1'b1;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr;
  logic [1:0]  bus_snoop = '0;
  logic        l1_valid, l1_ready = 1'b1;
  logic [2:0]  l1_msg;
  logic [31:0] l1_addr;
  logic        upd_valid, done;
  logic [2:0]  upd_way;
  logic [14:0] upd_index;
  logic [10:0] upd_tag;
  logic [1:0]  upd_state;
  logic [31:0] stat_hits, stat_misses, stat_wbacks;

  always #5 clk = ~clk;

  llc_req_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .lk_hit(lk_hit), .lk_hit_way(lk_hit_way), .lk_state(lk_state),
    .lk_victim_way(lk_victim_way), .lk_victim_state(lk_victim_state), .lk_victim_tag(lk_victim_tag),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_ready(bus_ready),
    .bus_snoop(bus_snoop), .l1_valid(l1_valid), .l1_msg(l1_msg), .l1_addr(l1_addr),
    .l1_ready(l1_ready), .upd_valid(upd_valid), .upd_way(upd_way), .upd_index(upd_index),
    .upd_tag(upd_tag), .upd_state(upd_state), .done(done), .stat_hits(stat_hits),
    .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted request expands into an ordered list of expected steps.
  localparam int K_BUS = 0, K_L1 = 1, K_UPD = 2;
  typedef struct { int kind; logic [2:0] op; logic [31:0] addr; } step_t;
  step_t q[$];
  logic        m_op, m_hit;
  logic [1:0]  m_st, m_snoop;
  logic [2:0]  m_way;
  logic [31:0] m_addr;
  logic [31:0] m_hits = 0, m_misses = 0, m_wbacks = 0;

  function automatic step_t mk(input int kind, input logic [2:0] op, input logic [31:0] addr);
    step_t s;
    s.kind = kind; s.op = op; s.addr = addr;
    return s;
  endfunction

  task automatic model_accept();
    logic [31:0] line, vline;
    line  = {req_addr[31:6], 6'b0};
    vline = {lk_victim_tag, req_addr[20:6], 6'b0};
    m_op = req_op; m_hit = lk_hit; m_st = lk_state; m_addr = req_addr; m_snoop = 2'd0;
    m_way = lk_hit ? lk_hit_way : lk_victim_way;
    if (lk_hit) begin
      m_hits++;
      if (req_op && lk_state == 2'd1) q.push_back(mk(K_BUS, 3'd3, line));
    end else begin
      m_misses++;
      if (lk_victim_state == 2'd3) begin
        m_wbacks++;
        q.push_back(mk(K_L1, 3'd1, vline));
        q.push_back(mk(K_L1, 3'd4, vline));
        q.push_back(mk(K_BUS, 3'd2, vline));
      end else if (lk_victim_state != 2'd0) begin
        q.push_back(mk(K_L1, 3'd4, vline));
      end
      q.push_back(mk(K_BUS, req_op ? 3'd4 : 3'd1, line));
    end
    q.push_back(mk(K_L1, 3'd2, line));
    q.push_back(mk(K_UPD, 3'd0, 32'd0));
  endtask

  function automatic logic [1:0] exp_state();
    if (m_op) return 2'd3;
    if (m_hit) return m_st;
    return (m_snoop == 2'd0) ? 2'd2 : 2'd1;
  endfunction

  task automatic chk_stats();
`ifdef LLC_REQ_SEQ_STATS_EN
    chk("stat_hits", stat_hits, m_hits);
    chk("stat_misses", stat_misses, m_misses);
    chk("stat_wbacks", stat_wbacks, m_wbacks);
`else
    chk("stat_hits", stat_hits, 32'd0);
    chk("stat_misses", stat_misses, 32'd0);
    chk("stat_wbacks", stat_wbacks, 32'd0);
`endif
  endtask

  // Compare process: every falling edge
  initial begin
    step_t hd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_hits = 0; m_misses = 0; m_wbacks = 0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {bus_valid, l1_valid, upd_valid, done}, 0);
        chk("rst_ops", {bus_op, l1_msg}, 0);
        chk("rst_addrs", bus_addr | l1_addr, 0);
        chk("rst_upd", {upd_way, upd_index, upd_tag, upd_state}, 0);
        chk_stats();
      end else begin
        chk("bus_l1_exclusive", bus_valid && l1_valid, 0);
        chk_stats();
        if (q.size() == 0) begin
          chk("idle_req_ready", req_ready, 1);
          chk("idle_valids", {bus_valid, l1_valid, upd_valid, done}, 0);
          if (req_valid) model_accept();
        end else begin
          hd = q[0];
          chk("busy_req_ready", req_ready, 0);
          case (hd.kind)
            K_BUS: begin
              chk("bus_valid", {bus_valid, l1_valid, upd_valid}, 3'b100);
              chk("bus_op", bus_op, hd.op);
              chk("bus_addr", bus_addr, hd.addr);
              if (bus_ready) begin
                if (hd.op == 3'd1 || hd.op == 3'd4) m_snoop = bus_snoop;
                void'(q.pop_front());
              end
            end
            K_L1: begin
              chk("l1_valid", {bus_valid, l1_valid, upd_valid}, 3'b010);
              chk("l1_msg", l1_msg, hd.op);
              chk("l1_addr", l1_addr, hd.addr);
              if (l1_ready) void'(q.pop_front());
            end
            default: begin
              chk("upd_valid", {bus_valid, l1_valid, upd_valid, done}, 4'b0011);
              chk("upd_way", upd_way, m_way);
              chk("upd_index", upd_index, m_addr[20:6]);
              chk("upd_tag", upd_tag, m_addr[31:21]);
              chk("upd_state", upd_state, exp_state());
              void'(q.pop_front());
            end
          endcase
        end
      end
    end
  end

  // Directed request with all readies high except an optional bus_ready stall; called at posedge+1.
  task automatic do_req(input logic op, input logic [31:0] addr, input logic hit,
                        input logic [2:0] hway, input logic [1:0] hst, input logic [2:0] vway,
                        input logic [1:0] vst, input logic [10:0] vtag, input logic [1:0] snoop,
                        input int stall, output int lat, output logic [1:0] ust,
                        output logic [2:0] uway);
    lat = -1; ust = 2'd0; uway = 3'd0;
    req_valid = 1; req_op = op; req_addr = addr; lk_hit = hit; lk_hit_way = hway;
    lk_state = hst; lk_victim_way = vway; lk_victim_state = vst; lk_victim_tag = vtag;
    bus_snoop = snoop; l1_ready = 1; bus_ready = (stall == 0);
    @(posedge clk); #1;
    req_valid = 0;
    lk_hit = ~hit; lk_state = ~hst; lk_victim_state = ~vst; lk_victim_tag = ~vtag;
    for (int n = 1; n <= 50; n++) begin
      if (done) begin
        lat = n; ust = upd_state; uway = upd_way;
        break;
      end
      if (stall > 0 && n == stall + 1) bus_ready = 1;
      @(posedge clk); #1;
    end
    bus_ready = 1;
    chk("req_done_seen", (lat > 0), 1);
    @(posedge clk); #1;
    chk("ready_after_done", req_ready, 1);
  endtask

  initial begin
    int lat;
    logic [1:0] ust;
    logic [2:0] uway;
    logic [31:0] wb0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_done", done, 0);
    rst_n = 1;
    @(posedge clk); #1;

    do_req(0, 32'h0020_0040, 1, 3'd3, 2'd2, 3'd0, 2'd0, 11'd0, 2'd0, 0, lat, ust, uway);
    chk("rd_hit_latency", lat, 2);
    chk("rd_hit_way", uway, 3);
    chk("rd_hit_state", ust, 2);

    do_req(1, 32'h1234_5678, 1, 3'd5, 2'd1, 3'd0, 2'd0, 11'd0, 2'd0, 0, lat, ust, uway);
    chk("wr_hit_s_latency", lat, 3);
    chk("wr_hit_s_state", ust, 3);

    do_req(0, 32'h0ABC_D0C0, 0, 3'd0, 2'd0, 3'd6, 2'd0, 11'h123, 2'd0, 0, lat, ust, uway);
    chk("rd_miss_nohit_latency", lat, 3);
    chk("rd_miss_nohit_state", ust, 2);
    chk("rd_miss_way", uway, 6);

    do_req(0, 32'h0ABC_D0C0, 0, 3'd0, 2'd0, 3'd6, 2'd0, 11'h123, 2'd2, 0, lat, ust, uway);
    chk("rd_miss_hitm_state", ust, 1);

    wb0 = stat_wbacks;
    do_req(1, 32'h00A0_0040, 0, 3'd0, 2'd0, 3'd1, 2'd3, 11'h7FF, 2'd0, 0, lat, ust, uway);
    chk("wr_miss_m_latency", lat, 6);
    chk("wr_miss_m_state", ust, 3);
    chk("wr_miss_m_way", uway, 1);
`ifdef LLC_REQ_SEQ_STATS_EN
    chk("wbacks_increment", stat_wbacks, wb0 + 32'd1);
`else
    chk("wbacks_tied_zero", stat_wbacks | wb0, 32'd0);
`endif

    do_req(0, 32'h4000_1FC0, 0, 3'd0, 2'd0, 3'd2, 2'd2, 11'h055, 2'd0, 0, lat, ust, uway);
    chk("rd_miss_e_victim_latency", lat, 4);

    do_req(0, 32'h0ABC_D0C0, 0, 3'd0, 2'd0, 3'd4, 2'd0, 11'h0, 2'd1, 5, lat, ust, uway);
    chk("stall_latency", lat, 8);
    chk("stall_state", ust, 1);

    // Reset in the middle of the writeback
    req_valid = 1; req_op = 1; req_addr = 32'h00A0_0040; lk_hit = 0;
    lk_victim_way = 3'd2; lk_victim_state = 2'd3; lk_victim_tag = 11'h7FF;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("wb_bus_valid", bus_valid, 1);
    chk("wb_bus_op", bus_op, 3'd2);
    chk("wb_bus_addr", bus_addr, 32'hFFE0_0040);
    #3 rst_n = 0;
    #1;
    chk("async_rst_bus_valid", bus_valid, 0);
    chk("async_rst_upd_valid", upd_valid, 0);
    chk("async_rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_no_upd", upd_valid, 0);
      chk("post_rst_ready", req_ready, 1);
    end

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      bus_ready       = ($urandom_range(0, 3) != 0);
      l1_ready        = ($urandom_range(0, 3) != 0);
      bus_snoop       = 2'($urandom_range(0, 3));
      req_valid       = ($urandom_range(0, 2) == 0);
      req_op          = 1'($urandom_range(0, 1));
      req_addr        = $urandom;
      lk_hit          = 1'($urandom_range(0, 1));
      lk_hit_way      = 3'($urandom_range(0, 7));
      lk_state        = 2'($urandom_range(1, 3));
      lk_victim_way   = 3'($urandom_range(0, 7));
      lk_victim_state = 2'($urandom_range(0, 3));
      lk_victim_tag   = 11'($urandom_range(0, 2047));
      @(posedge clk); #1;
    end
    req_valid = 0; bus_ready = 1; l1_ready = 1;
    repeat (12) begin @(posedge clk); #1; end
    chk("drain_idle", req_ready, 1);
    chk("drain_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
